// File: rtl/lock_timer_arbiter_if.sv
// Request/grant/timer bundle shared by the lock timer arbiter and its requesters.
// The slave side is the arbiter; the master side is the requester pair.
interface lock_timer_arbiter_if #(
    parameter int W = 8
);
    logic         tick;
    logic [1:0]   req;
    logic [W-1:0] dur0;
    logic [W-1:0] dur1;
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic [W-1:0] remaining;

    modport master (
        output tick, req, dur0, dur1,
        input  gnt, busy, done, remaining
    );

    modport slave (
        input  tick, req, dur0, dur1,
        output gnt, busy, done, remaining
    );
endinterface

// File: rtl/lock_timer_arbiter.sv
// Two-requester round-robin arbiter that grants a single shared countdown timer,
// counting down on time-base ticks and pulsing done when the timer expires.
module lock_timer_arbiter #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lock_timer_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic         busy_q, busy_d;
    logic [1:0]   done_q, done_d;
    logic [W-1:0] remaining_q, remaining_d;
    logic         ptr_q, ptr_d;       // last-served requester index
    logic         winner_q, winner_d; // requester currently holding the timer
    logic         sel;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        done_d      = 2'b00;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        // Under contention favour the requester that was not served last.
        sel         = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    winner_d    = sel;
                    gnt_d       = sel ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    remaining_d = sel ? bus.dur1 : bus.dur0;
                    state_d     = (remaining_d == '0) ? EXPIRE : RUN;
                end
            end
            RUN: begin
                // Abort wins over any tick arriving in the same cycle.
                if (!bus.req[winner_q]) begin
                    state_d     = IDLE;
                    gnt_d       = 2'b00;
                    busy_d      = 1'b0;
                    remaining_d = '0;
                    ptr_d       = winner_q;
                end else if (bus.tick && remaining_q != '0) begin
                    remaining_d = remaining_q - W'(1);
                    if (remaining_q == W'(1)) begin
                        state_d = EXPIRE;
                    end
                end
            end
            EXPIRE: begin
                done_d  = winner_q ? 2'b10 : 2'b01;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                ptr_d   = winner_q;
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 2'b00;
                busy_d      = 1'b0;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 2'b00;
            remaining_q <= '0;
            ptr_q       <= 1'b1;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_lock_timer_arbiter.sv
// Directed bench: stimulus pushes expected grant/done events, a negedge monitor
// pops and compares them whenever the arbiter presents a grant or a done pulse.
module tb_lock_timer_arbiter;
    logic clk;
    logic rst;

    lock_timer_arbiter_if #(.W(8)) bus ();

    lock_timer_arbiter #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic       is_done;
        logic [1:0] bits;
        logic [7:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req_val);
        n_checks++;
        if (act != req_val) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req_val);
        end
    endtask

    task automatic push(input logic is_done, input logic [1:0] bits, input logic [7:0] rem);
        exp_t e;
        e.is_done = is_done;
        e.bits    = bits;
        e.rem     = rem;
        exp_q.push_back(e);
    endtask

    task automatic expect_evt(input logic is_done, input logic [1:0] bits, input logic [7:0] rem);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_%s: got bits=%b rem=%0d expected no event",
                     is_done ? "done" : "grant", bits, rem);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done || e.bits != bits || (!is_done && e.rem != rem)) begin
                n_errors++;
                $display("FAIL event: got %s bits=%b rem=%0d expected %s bits=%b rem=%0d",
                         is_done ? "done" : "grant", bits, rem,
                         e.is_done ? "done" : "grant", e.bits, e.rem);
            end else begin
                $display("event %s bits=%b rem=%0d ok", is_done ? "done" : "grant", bits, rem);
            end
        end
    endtask

    // Monitor: invariants every cycle, events on grant rise and done pulse.
    initial begin
        logic [1:0] gnt_prev;
        gnt_prev = 2'b00;
        forever begin
            @(negedge clk);
            n_checks++;
            if ((bus.gnt & bus.done) != 2'b00 || bus.done == 2'b11 || bus.gnt == 2'b11) begin
                n_errors++;
                $display("FAIL invariant: gnt=%b done=%b", bus.gnt, bus.done);
            end
            if (gnt_prev == 2'b00 && bus.gnt != 2'b00) expect_evt(1'b0, bus.gnt, bus.remaining);
            if (bus.done != 2'b00) expect_evt(1'b1, bus.done, 8'd0);
            gnt_prev = bus.gnt;
        end
    end

    initial begin
        rst      = 1'b1;
        bus.tick = 1'b0;
        bus.req  = 2'b00;
        bus.dur0 = 8'd0;
        bus.dur1 = 8'd0;
        #1;
        chk("reset_gnt", bus.gnt, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_remaining", bus.remaining, 0);
        step();
        rst = 1'b0;

        // Single requester, tick every 4 cycles.
        bus.req = 2'b01; bus.dur0 = 8'd3;
        push(1'b0, 2'b01, 8'd3);
        step();
        chk("single_gnt", bus.gnt, 1);
        chk("single_busy", bus.busy, 1);
        chk("single_rem0", bus.remaining, 3);
        for (int k = 1; k <= 3; k++) begin
            repeat (3) step();
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            chk("single_rem_tick", bus.remaining, 3 - k);
        end
        push(1'b1, 2'b01, 8'd0);
        step();
        chk("single_done", bus.done, 1);
        bus.req = 2'b00;
        step();
        chk("single_busy_after", bus.busy, 0);
        chk("single_done_once", bus.done, 0);

        // Contention from reset; a tick on the grant edge is ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 2'b11; bus.dur0 = 8'd2; bus.dur1 = 8'd5; bus.tick = 1'b1;
        push(1'b0, 2'b01, 8'd2);
        step();
        chk("contend_gnt", bus.gnt, 1);
        chk("contend_tick_at_grant", bus.remaining, 2);
        step();
        chk("contend_rem1", bus.remaining, 1);
        step();
        bus.tick = 1'b0;
        push(1'b1, 2'b01, 8'd0);
        step();
        bus.req = 2'b10;
        push(1'b0, 2'b10, 8'd5);
        step();
        chk("contend_gnt1", bus.gnt, 2);
        bus.tick = 1'b1;
        repeat (5) step();
        bus.tick = 1'b0;
        chk("contend_rem_end", bus.remaining, 0);
        push(1'b1, 2'b10, 8'd0);
        step();
        bus.req = 2'b00;
        step();

        // Round-robin fairness with both requesting continuously.
        bus.req = 2'b11; bus.dur0 = 8'd1; bus.dur1 = 8'd1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            push(1'b0, g, 8'd1);
            step();
            chk("fair_gnt", bus.gnt, int'(g));
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            push(1'b1, g, 8'd0);
            step();
        end
        bus.req = 2'b00;
        step();

        // Abort together with a tick at remaining=6, req0 pending.
        bus.req = 2'b10; bus.dur1 = 8'd10;
        push(1'b0, 2'b10, 8'd10);
        step();
        bus.tick = 1'b1;
        repeat (4) step();
        chk("abort_rem6", bus.remaining, 6);
        bus.req = 2'b01; bus.dur0 = 8'd2;
        step();
        bus.tick = 1'b0;
        chk("abort_gnt", bus.gnt, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rem", bus.remaining, 0);
        chk("abort_done", bus.done, 0);
        push(1'b0, 2'b01, 8'd2);
        step();
        chk("abort_next_gnt", bus.gnt, 1);
        bus.tick = 1'b1;
        repeat (2) step();
        bus.tick = 1'b0;
        push(1'b1, 2'b01, 8'd0);
        step();
        bus.req = 2'b00;
        step();

        // Zero duration: done without any tick.
        bus.req = 2'b01; bus.dur0 = 8'd0;
        push(1'b0, 2'b01, 8'd0);
        step();
        chk("zero_gnt", bus.gnt, 1);
        push(1'b1, 2'b01, 8'd0);
        step();
        chk("zero_done", bus.done, 1);
        chk("zero_gnt_clear", bus.gnt, 0);
        bus.req = 2'b00;
        step();

        // Asynchronous reset mid-RUN at remaining=4.
        bus.req = 2'b10; bus.dur1 = 8'd8;
        push(1'b0, 2'b10, 8'd8);
        step();
        bus.tick = 1'b1;
        repeat (4) step();
        bus.tick = 1'b0;
        chk("rstrun_rem4", bus.remaining, 4);
        #2 rst = 1'b1;
        #1;
        chk("rstrun_gnt", bus.gnt, 0);
        chk("rstrun_busy", bus.busy, 0);
        chk("rstrun_rem", bus.remaining, 0);
        step();
        rst = 1'b0;
        bus.req = 2'b11; bus.dur0 = 8'd1;
        push(1'b0, 2'b01, 8'd1);
        step();
        chk("rstrun_regrant", bus.gnt, 1);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.req = 2'b01;
        push(1'b1, 2'b01, 8'd0);
        step();
        bus.req = 2'b00;
        repeat (3) step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
